// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants and state encoding
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones until reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// rtl/fetch_ifid_ctrl.sv - PC register and IF/ID pipeline register with stall/flush control
module fetch_ifid_ctrl
    import riscv_pkg::*;
#(
    parameter int              PC_W          = 32,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              FLUSH_BUBBLES = 0,
    parameter int              CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard_n,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic [31:0]       imem_rdata,
    output logic [PC_W-1:0]   imem_addr,
    output logic [PC_W-1:0]   ifid_pc,
    output logic [31:0]       ifid_instr,
    output logic              ifid_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [PC_W-1:0] ALIGN_MASK  = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_STEP     = {{(PC_W-3){1'b0}}, 3'd4};
    localparam logic [1:0]      BUBBLE_INIT = 2'(FLUSH_BUBBLES);

    fetch_state_t      state_q, state_d;
    logic [1:0]        bubble_q, bubble_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              stall_inc, flush_inc;

    always_comb begin
        state_d      = state_q;
        bubble_d     = bubble_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        // A redirect overrides everything, including an in-progress bubble sequence.
        if (redirect) begin
            pc_d         = redirect_pc & ALIGN_MASK;
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            flush_inc    = 1'b1;
            bubble_d     = BUBBLE_INIT;
            state_d      = (FLUSH_BUBBLES == 0) ? RUN : FLUSH;
        end else begin
            case (state_q)
                FLUSH: begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    bubble_d     = bubble_q - 2'd1;
                    if (bubble_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
                RUN, STALL: begin
                    if (!hazard_n) begin
                        stall_inc = 1'b1;
                        state_d   = STALL;
                    end else begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + PC_STEP;
                        state_d      = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            bubble_q     <= 2'd0;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bubble_q     <= bubble_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// tb/tb_fetch_ifid_ctrl.sv - scoreboard bench for fetch_ifid_ctrl, wide and narrow configurations
module tb_fetch_ifid_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] stall;
        logic [31:0] flush;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hazard_n;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Configuration 0: defaults. Configuration 1: narrow PC, tiny counters, two extra bubbles.
    logic [31:0] addr0, ifpc0, instr0, rdata0;
    logic        valid0;
    logic [15:0] stall0, flush0;
    logic [7:0]  addr1, ifpc1;
    logic [31:0] instr1, rdata1;
    logic        valid1;
    logic [1:0]  stall1, flush1;

    int vectors = 0;
    int miscompares = 0;

    obs_t q0[$];
    obs_t q1[$];

    logic [31:0] m_pc[2], m_ifpc[2], m_instr[2], m_stall[2], m_flush[2];
    logic        m_valid[2];
    int          m_bubbles[2];
    logic [31:0] pcmask[2];
    logic [31:0] cntmax[2];
    int          fb[2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rdata0 = mem_word(addr0);
    assign rdata1 = mem_word({24'h0, addr1});

    always #5 clk = ~clk;

    fetch_ifid_ctrl dut0 (
        .clk         (clk),
        .reset       (reset),
        .hazard_n    (hazard_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rdata  (rdata0),
        .imem_addr   (addr0),
        .ifid_pc     (ifpc0),
        .ifid_instr  (instr0),
        .ifid_valid  (valid0),
        .stall_cnt   (stall0),
        .flush_cnt   (flush0)
    );

    fetch_ifid_ctrl #(
        .PC_W          (8),
        .RESET_PC      (8'h00),
        .FLUSH_BUBBLES (2),
        .CNT_W         (2)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .hazard_n    (hazard_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc[7:0]),
        .imem_rdata  (rdata1),
        .imem_addr   (addr1),
        .ifid_pc     (ifpc1),
        .ifid_instr  (instr1),
        .ifid_valid  (valid1),
        .stall_cnt   (stall1),
        .flush_cnt   (flush1)
    );

    // Reference model: what the pipeline front end should look like after one clock edge.
    task automatic model_step(input int d, input logic rst, input logic haz,
                              input logic redir, input logic [31:0] tgt, output obs_t o);
        if (rst) begin
            m_pc[d] = 32'h0; m_ifpc[d] = 32'h0; m_instr[d] = 32'h13; m_valid[d] = 1'b0;
            m_stall[d] = 32'h0; m_flush[d] = 32'h0; m_bubbles[d] = 0;
        end else if (redir) begin
            m_pc[d]    = tgt & pcmask[d] & ~32'h3;
            m_ifpc[d]  = 32'h0;
            m_instr[d] = 32'h13;
            m_valid[d] = 1'b0;
            if (m_flush[d] < cntmax[d]) m_flush[d] = m_flush[d] + 1;
            m_bubbles[d] = fb[d];
        end else if (m_bubbles[d] > 0) begin
            m_instr[d] = 32'h13;
            m_valid[d] = 1'b0;
            m_bubbles[d] = m_bubbles[d] - 1;
        end else if (!haz) begin
            if (m_stall[d] < cntmax[d]) m_stall[d] = m_stall[d] + 1;
        end else begin
            m_ifpc[d]  = m_pc[d];
            m_instr[d] = mem_word(m_pc[d]);
            m_valid[d] = 1'b1;
            m_pc[d]    = (m_pc[d] + 32'd4) & pcmask[d];
        end
        o = '{pc: m_pc[d], ifpc: m_ifpc[d], instr: m_instr[d], valid: m_valid[d],
              stall: m_stall[d], flush: m_flush[d]};
    endtask

    task automatic cycle(input logic rst, input logic haz, input logic redir, input logic [31:0] tgt);
        obs_t e0, e1;
        @(negedge clk);
        reset = rst; hazard_n = haz; redirect = redir; redirect_pc = tgt;
        model_step(0, rst, haz, redir, tgt, e0);
        model_step(1, rst, haz, redir, tgt, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic compare(input string name, input obs_t e, input obs_t a);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: got pc=%h ifpc=%h instr=%h v=%b st=%0d fl=%0d expected pc=%h ifpc=%h instr=%h v=%b st=%0d fl=%0d",
                     name, $time, a.pc, a.ifpc, a.instr, a.valid, a.stall, a.flush,
                     e.pc, e.ifpc, e.instr, e.valid, e.stall, e.flush);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            compare("cfg0", q0.pop_front(),
                    '{pc: addr0, ifpc: ifpc0, instr: instr0, valid: valid0,
                      stall: {16'h0, stall0}, flush: {16'h0, flush0}});
        end
        if (q1.size() > 0) begin
            compare("cfg1", q1.pop_front(),
                    '{pc: {24'h0, addr1}, ifpc: {24'h0, ifpc1}, instr: instr1, valid: valid1,
                      stall: {30'h0, stall1}, flush: {30'h0, flush1}});
        end
    end

    initial begin
        pcmask[0] = 32'hFFFF_FFFF; cntmax[0] = 32'h0000_FFFF; fb[0] = 0;
        pcmask[1] = 32'h0000_00FF; cntmax[1] = 32'h0000_0003; fb[1] = 2;
        reset = 1'b1; hazard_n = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (3) cycle(0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 32'h103);
        repeat (3) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h40);
        repeat (4) cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'hFFFF_FFF6);
        repeat (5) cycle(0, 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 32'h88);
        cycle(0, 1, 1, 32'h20);
        cycle(1, 1, 1, 32'h60);
        cycle(0, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 7) == 0),
                  $urandom());
        end

        @(negedge clk);
        reset = 1'b0; hazard_n = 1'b1; redirect = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
